// File: rtl/mp16_arb.sv
// mp16_arb: round-robin sharing of one 16x16 multiplier between two requesters.
// Define MP16_ACC_SAT_EN to saturate MAC accumulation instead of wrapping.
module mp16_arb #(
  parameter int ACCW = 40
) (
  input  logic            sys_clk,
  input  logic            resetl,
  input  logic            r0_req,
  input  logic [1:0]      r0_op,
  input  logic            r0_sign,
  input  logic [15:0]     r0_a,
  input  logic [15:0]     r0_b,
  output logic            r0_ack,
  output logic            r0_done,
  output logic [31:0]     r0_res,
  output logic [ACCW-1:0] r0_acc,
  input  logic            r1_req,
  input  logic [1:0]      r1_op,
  input  logic            r1_sign,
  input  logic [15:0]     r1_a,
  input  logic [15:0]     r1_b,
  output logic            r1_ack,
  output logic            r1_done,
  output logic [31:0]     r1_res,
  output logic [ACCW-1:0] r1_acc,
  output logic [15:0]     mul_a,
  output logic [15:0]     mul_b,
  output logic            mul_sign,
  input  logic [31:0]     mul_q,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            rr_q, rr_d;
  logic            gid_q, gid_d;
  logic [1:0]      op_q, op_d;
  logic [15:0]     mul_a_q, mul_a_d;
  logic [15:0]     mul_b_q, mul_b_d;
  logic            mul_sign_q, mul_sign_d;
  logic [31:0]     prod_q, prod_d;
  logic [1:0]      ack_q, ack_d;
  logic [1:0]      done_q, done_d;
  logic [31:0]     res0_q, res0_d;
  logic [31:0]     res1_q, res1_d;
  logic [ACCW-1:0] acc0_q, acc0_d;
  logic [ACCW-1:0] acc1_q, acc1_d;

  logic            any_req;
  logic            gnt;
  logic            take;
  logic            is_mac;
  logic            is_clr;
  logic [ACCW-1:0] acc_cur;
  logic [ACCW-1:0] prod_ext;
  logic [ACCW-1:0] mac_val;
  logic [ACCW-1:0] acc_new;

  always_comb begin
    acc_cur  = gid_q ? acc1_q : acc0_q;
    prod_ext = mul_sign_q ? {{(ACCW-32){prod_q[31]}}, prod_q}
                          : {{(ACCW-32){1'b0}}, prod_q};
  end

`ifdef MP16_ACC_SAT_EN
  logic [ACCW:0] sum_x;

  // one guard bit exposes signed overflow or unsigned carry-out
  always_comb begin
    if (mul_sign_q) begin
      sum_x = {acc_cur[ACCW-1], acc_cur} + {prod_ext[ACCW-1], prod_ext};
      if (sum_x[ACCW] != sum_x[ACCW-1]) begin
        mac_val = sum_x[ACCW] ? {1'b1, {(ACCW-1){1'b0}}}
                              : {1'b0, {(ACCW-1){1'b1}}};
      end else begin
        mac_val = sum_x[ACCW-1:0];
      end
    end else begin
      sum_x   = {1'b0, acc_cur} + {1'b0, prod_ext};
      mac_val = sum_x[ACCW] ? {ACCW{1'b1}} : sum_x[ACCW-1:0];
    end
  end
`else
  always_comb begin
    mac_val = acc_cur + prod_ext;
  end
`endif

  always_comb begin
    any_req = r0_req | r1_req;
    gnt     = (r0_req & r1_req) ? rr_q : r1_req;
    take    = any_req & ((state_q == S_IDLE) | (state_q == S_WB));
    is_mac  = (op_q == 2'b01);
    is_clr  = (op_q == 2'b10);

    state_d    = state_q;
    rr_d       = rr_q;
    gid_d      = gid_q;
    op_d       = op_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    mul_sign_d = mul_sign_q;
    prod_d     = prod_q;
    ack_d      = 2'b00;
    done_d     = 2'b00;
    res0_d     = res0_q;
    res1_d     = res1_q;
    acc0_d     = acc0_q;
    acc1_d     = acc1_q;
    acc_new    = acc_cur;

    unique case (state_q)
      S_IDLE: ;
      S_MUL: begin
        prod_d  = mul_q;
        state_d = S_WB;
      end
      S_WB: begin
        state_d        = S_IDLE;
        done_d[gid_q]  = 1'b1;
        unique case (1'b1)
          is_clr: acc_new = '0;
          is_mac: acc_new = mac_val;
          default: ;
        endcase
        if (!is_clr) begin
          if (gid_q) res1_d = prod_q;
          else       res0_d = prod_q;
        end
        if (gid_q) acc1_d = acc_new;
        else       acc0_d = acc_new;
      end
      default: state_d = S_IDLE;
    endcase

    // a grant in WB overlaps the new ack with the previous done
    if (take) begin
      state_d    = S_MUL;
      gid_d      = gnt;
      rr_d       = ~gnt;
      op_d       = gnt ? r1_op   : r0_op;
      mul_a_d    = gnt ? r1_a    : r0_a;
      mul_b_d    = gnt ? r1_b    : r0_b;
      mul_sign_d = gnt ? r1_sign : r0_sign;
      ack_d[gnt] = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      state_q    <= S_IDLE;
      rr_q       <= 1'b0;
      gid_q      <= 1'b0;
      op_q       <= 2'b00;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      mul_sign_q <= 1'b0;
      prod_q     <= '0;
      ack_q      <= 2'b00;
      done_q     <= 2'b00;
      res0_q     <= '0;
      res1_q     <= '0;
      acc0_q     <= '0;
      acc1_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      gid_q      <= gid_d;
      op_q       <= op_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      mul_sign_q <= mul_sign_d;
      prod_q     <= prod_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      res0_q     <= res0_d;
      res1_q     <= res1_d;
      acc0_q     <= acc0_d;
      acc1_q     <= acc1_d;
    end
  end

  assign r0_ack   = ack_q[0];
  assign r1_ack   = ack_q[1];
  assign r0_done  = done_q[0];
  assign r1_done  = done_q[1];
  assign r0_res   = res0_q;
  assign r1_res   = res1_q;
  assign r0_acc   = acc0_q;
  assign r1_acc   = acc1_q;
  assign mul_a    = mul_a_q;
  assign mul_b    = mul_b_q;
  assign mul_sign = mul_sign_q;
  assign busy     = (state_q == S_MUL) | (state_q == S_WB);

endmodule
